ysyx_22041071_axi_rd_slave: RTL

- AXI-style read responder on the memory side of the instruction-fetch read channel.
- Accepts one read-address request at a time (addr/len/size) from a fetch initiator.
- Reads a synchronous SRAM once per beat and returns R beats with rdata/rresp/rlast under r_ready backpressure.
- Sits between the CPU AXI read port and the SRAM model used by the simulation top.

---
 rtl/ysyx_22041071_axi_rd_slave_pkg.sv | 31 +++
 rtl/ysyx_22041071_axi_rd_slave.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_axi_rd_slave_pkg.sv
// Shared codes for the fetch-side AXI read responder.
// Response, size, len-width and FSM state encodings.
package ysyx_22041071_axi_rd_slave_pkg;

  localparam int AXI_LEN_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } rd_state_e;

  // Subtract-then-compare so BASE+MEM_BYTES never has to be formed.
  function automatic logic in_window(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [63:0] bytes
  );
    return (addr >= base) && ((addr - base) < bytes);
  endfunction

endpackage

// File: rtl/ysyx_22041071_axi_rd_slave.sv
// AXI read responder: one burst at a time, one SRAM read per beat.
// Define YSYX_22041071_RD_DECERR_EN to answer out-of-window beats with DECERR.
module ysyx_22041071_axi_rd_slave
  import ysyx_22041071_axi_rd_slave_pkg::*;
#(
  parameter int          ADDR_W    = 64,
  parameter int          DATA_W    = 64,
  parameter int          LEN_W     = AXI_LEN_W,
  parameter logic [63:0] BASE      = 64'h8000_0000,
  parameter logic [63:0] MEM_BYTES = 64'h0800_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [LEN_W-1:0]  ar_len,
  input  logic [1:0]        ar_size,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              mem_ren,
  output logic [ADDR_W-4:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef YSYX_22041071_RD_DECERR_EN
  localparam logic CHECK = 1'b1;
`else
  localparam logic CHECK = 1'b0;
`endif

  rd_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [1:0]        size_q, size_d;

  logic              r_valid_q, r_valid_d;
  logic              r_last_q, r_last_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [1:0]        r_resp_q, r_resp_d;
  logic              mem_ren_q, mem_ren_d;
  logic [ADDR_W-4:0] mem_addr_q, mem_addr_d;

  logic              last_beat;
  logic              ok_cur;
  logic              ok_next;
  logic [ADDR_W-1:0] step;

  assign last_beat = (beat_q == len_q);
  assign step = {{(ADDR_W-1){1'b0}}, 1'b1} << size_q;

  assign ok_cur  = ~CHECK
                 | in_window(64'(addr_q), BASE, MEM_BYTES);
  assign ok_next = ~CHECK
                 | in_window(64'(addr_d), BASE, MEM_BYTES);

  assign ar_ready = (state_q == ST_IDLE) & ~reset;

  assign r_valid  = r_valid_q;
  assign r_last   = r_last_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign mem_ren  = mem_ren_q;
  assign mem_addr = mem_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      size_q     <= '0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      size_q     <= size_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      mem_ren_q  <= mem_ren_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    size_d  = size_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ar_valid) begin
          addr_d  = ar_addr;
          len_d   = ar_len;
          size_d  = ar_size;
          beat_d  = '0;
          state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: state_d = ST_RESP;
      ST_RESP: begin
        if (r_ready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            addr_d  = addr_q + step;
            state_d = ST_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state.
  always_comb begin
    r_valid_d  = (state_d == ST_RESP);
    r_last_d   = r_last_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    mem_ren_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    if (state_d == ST_RD) begin
      mem_ren_d  = ok_next;
      mem_addr_d = addr_d[ADDR_W-1:3];
    end
    if (state_q == ST_WAIT) begin
      r_data_d = ok_cur ? mem_rdata : '0;
      r_resp_d = ok_cur ? RESP_OKAY : RESP_DECERR;
      r_last_d = last_beat;
    end
  end

endmodule
